// File: rtl/fetch_queue_pkg.sv
// Shared constants and redirect priority encoding for the instruction fetch queue.
package fetch_queue_pkg;

    localparam int          DEFAULT_DEPTH    = 4;
    localparam int unsigned DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_RF   = 2'd1,
        REDIR_DM   = 2'd2
    } redirect_sel_t;

    // The DM stage resolves later than RF, so a DM misprediction overrides an RF prediction.
    function automatic redirect_sel_t redirect_select(input logic dm, input logic rf);
        redirect_sel_t sel;
        sel = REDIR_NONE;
        if (dm) begin
            sel = REDIR_DM;
        end else if (rf) begin
            sel = REDIR_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head word is read straight from registered storage.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A flush cancels any push/pop presented in the same cycle.
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC register with redirect mux feeding a small queue toward the ID stage.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = DEFAULT_DEPTH,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_address,
    input  logic [31:0]     imem_data,
    input  logic            redirect_dm,
    input  logic [XLEN-1:0] redirect_dm_target,
    input  logic            redirect_rf,
    input  logic [XLEN-1:0] redirect_rf_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instruction,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus_four,
    output logic            fetch_stall
);

    localparam int EW = 32 + 2 * XLEN;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_four;
    logic [XLEN-1:0] redirect_target;
    redirect_sel_t   redirect_sel;
    logic            redirect;
    logic            dequeue;
    logic            fetch_en;
    logic [CW-1:0]   count;
    logic            full;
    logic [EW-1:0]   head;

    assign redirect_sel = redirect_select(redirect_dm, redirect_rf);
    assign redirect     = (redirect_sel != REDIR_NONE);

    always_comb begin
        redirect_target = pc;
        case (redirect_sel)
            REDIR_DM: redirect_target = redirect_dm_target;
            REDIR_RF: redirect_target = redirect_rf_target;
            default:  redirect_target = pc;
        endcase
    end

    // Handshake: the head entry transfers on a cycle where out_valid && out_ready are both
    // high; out_valid never depends on out_ready and the head holds until it is taken.
    assign out_valid    = (count != '0);
    assign full         = (count == CW'(DEPTH));
    assign dequeue      = out_valid && out_ready && !redirect;
    assign fetch_en     = !redirect && (!full || (out_valid && out_ready));
    assign fetch_stall  = reset && !fetch_en;
    assign pc_plus_four = pc + XLEN'(4);
    assign imem_address = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= {redirect_target[XLEN-1:2], 2'b00};
        end else if (fetch_en) begin
            pc <= pc_plus_four;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (fetch_en),
        .pop   (dequeue),
        .wdata ({imem_data, pc, pc_plus_four}),
        .rdata (head),
        .count (count)
    );

    assign out_instruction  = head[EW-1 -: 32];
    assign out_pc           = head[2*XLEN-1 -: XLEN];
    assign out_pc_plus_four = head[XLEN-1:0];

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 imem_address  output  XLEN  fetch address to asynchronous instruction memory; equals current PC.
REQ-007 imem_data  input  32  instruction returned combinationally for imem_address.
REQ-008 redirect_dm  input  1  DM-stage misprediction redirect request.
REQ-009 redirect_dm_target  input  XLEN  evaluated next-instruction address.
REQ-010 redirect_rf  input  1  RF-stage predicted-taken redirect request.
REQ-011 redirect_rf_target  input  XLEN  predicted branch target.
REQ-012 out_valid  output  1  head entry valid toward ID stage.
REQ-013 out_ready  input  1  ID stage accepts head entry this cycle.
REQ-014 out_instruction  output  32  head entry instruction.
REQ-015 out_pc  output  XLEN  head entry PC.
REQ-016 out_pc_plus_four  output  XLEN  head entry PC + 4.
REQ-017 fetch_stall  output  1  high when no fetch is enqueued this cycle.

Function
REQ-018 Fetch: when not redirecting and (count < DEPTH, or count == DEPTH with out_valid && out_ready), the entry {imem_data, PC, PC+4} SHALL be enqueued and PC SHALL advance by 4.
REQ-019 Any other cycle SHALL hold PC, enqueue nothing, and assert fetch_stall.
REQ-020 Latency: an entry fetched in cycle N SHALL appear at the head, with out_valid high, in cycle N+1 at the earliest.
REQ-021 out_valid SHALL equal (count != 0); head outputs are driven from registered storage only, with no combinational path from imem_data.
REQ-022 Dequeue SHALL occur exactly when out_valid && out_ready; entries leave in FIFO order.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count unchanged, including at count == DEPTH.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-025 Redirect: if redirect_dm or redirect_rf is high, the queue SHALL be emptied at the edge (count 0), and the enqueue and dequeue of that cycle are discarded.
REQ-026 On redirect, PC SHALL load the target with bits [1:0] forced to 0.
REQ-027 If both redirects are high, redirect_dm SHALL take priority.
REQ-028 After a redirect in cycle N, the first fetch from the target occurs in cycle N+1, and out_valid SHALL first rise in cycle N+2.
REQ-029 PC + 4 SHALL wrap modulo 2^XLEN without flagging.
REQ-030 While out_valid is low, head outputs SHALL be don't-care; while valid and not dequeued, they SHALL remain stable.

Reset
REQ-031 While reset is low: PC = RESET_PC, count = 0, pointers = 0, out_valid = 0, and fetch_stall = 0.
REQ-032 Assertion of reset mid-operation SHALL discard all queued entries immediately, without waiting for clk.
REQ-033 The first fetch SHALL occur at RESET_PC on the first rising edge after reset deasserts.

Structure
REQ-034 A shared package SHALL hold the default DEPTH and RESET_PC constants and the redirect priority encoding; entry fields are parameterized by XLEN locally.
REQ-035 Storage SHALL be one sub-module, fetch_fifo, a synchronous FIFO with flush, push/pop, and count, instantiated with width 32 + 2*XLEN.
REQ-036 The PC register and redirect mux SHALL live in fetch_queue.

Verification
REQ-037 Reset, then out_ready=1, with memory holding 0x00000013 at each word -> out_valid from cycle 2; out_pc sequence 0, 4, 8, ...; fetch_stall never high.
REQ-038 out_ready=0 for 10 cycles after reset (DEPTH=4) -> count saturates at 4, imem_address holds 0x10, and fetch_stall is high from the 5th cycle; releasing out_ready drains entries 0x0 through 0xC in order.
REQ-039 Queue full with out_ready=1 -> push and pop occur together, count stays 4, and PC advances by 4 each cycle.
REQ-040 redirect_rf=1 with target 0x40 while 3 entries are queued -> next cycle out_valid=0 and imem_address=0x40; the following cycle out_pc=0x40.
REQ-041 redirect_dm (target 0x20) and redirect_rf (target 0x60) in the same cycle -> PC=0x20; target 0x23 -> PC=0x20.
REQ-042 Reset asserted while the queue is full -> out_valid drops before the next clk edge, and after release fetch restarts at RESET_PC.
